fetch_pc_ctrl: RTL and testbench
================================

Name: fetch_pc_ctrl

Overview:
- Upstream neighbour of the instruction_fetch block.
- Holds the program counter and drives it to the combinational fetch memory. Captures the returned instruction into an IF/ID pipeline register with a valid/ready handshake toward decode.
- Handles branch redirects, invalid-address faults and a halt instruction.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- HALT_INSTR, 32'h00000073, encoding that halts fetch when captured.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  branch/jump redirect request from execute.
- redirect_pc  in  64  redirect target.
- id_ready  in  1  decode can accept the IF/ID entry this cycle.
- fetch_instr  in  32  instruction returned by fetch for the current pc.
- fetch_inv_addr  in  1  fetch flags the current pc as invalid.
- pc  out  64  current PC, driven to fetch directly from the PC register.
- if_valid  out  1  IF/ID entry valid.
- if_pc  out  64  PC of the IF/ID entry.
- if_instr  out  32  instruction of the IF/ID entry.
- fault  out  1  high while in S_FAULT.
- fault_pc  out  64  PC that caused the last fault.
- halted  out  1  high while in S_HALT.

Behaviour:
- Reset (async, active-high) values:
  - pc=RESET_PC.
  - if_valid=0, if_pc=0, if_instr=0.
  - fault=0, fault_pc=0, halted=0.
  - state=S_RUN.
- States: S_RUN, S_FAULT, S_HALT, 2-bit encoding.
- slot_free = !if_valid || id_ready.
- Entry consumed: the IF/ID entry is consumed on any clk edge with if_valid && id_ready.
- S_RUN, no redirect, fetch_inv_addr=0, slot_free:
  - Load if_pc<=pc and if_instr<=fetch_instr; set if_valid<=1.
  - pc<=pc+PC_STEP, modulo 2^64 (wraps 64'hFFFF_FFFF_FFFF_FFFC -> 0).
  - Latency: one cycle from pc to the IF/ID entry.
- S_RUN, !slot_free (stall): pc and the IF/ID entry hold.
- S_RUN, fetch_inv_addr=1, no redirect:
  - No load; state<=S_FAULT; fault_pc<=pc; pc holds.
  - An already-valid entry still drains normally via id_ready.
- Captured instruction equal to HALT_INSTR:
  - The entry loads normally.
  - pc does not advance.
  - state<=S_HALT.
- Redirect (redirect_valid=1) has highest priority in S_RUN and S_FAULT:
  - pc<=redirect_pc.
  - if_valid<=0; a same-cycle load is dropped and the held entry is flushed.
  - state<=S_RUN.
  - fault clears, fault_pc keeps its value.
- Redirect in S_HALT: ignored; only reset leaves S_HALT.
- S_FAULT without redirect: pc holds, no loads, entry drains.
- S_HALT: pc holds, no loads, entry drains.
- Misaligned redirect_pc: accepted as given. The fetch block flags it the next cycle and the block enters S_FAULT.
- fault and halted are registered decodes of state.
- Reset asserted mid-stall or mid-fault: all state returns to reset values immediately.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, add output ports fetch_count[31:0] and stall_count[31:0], both reset to 0:
  - fetch_count increments on every IF/ID load.
  - stall_count increments on every S_RUN cycle with !slot_free.
  - Both wrap at 2^32 and are not cleared by redirect.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg holds:
  - The state enum (S_RUN=0, S_FAULT=1, S_HALT=2).
  - XLEN=64 and ILEN=32.
  - Default HALT_INSTR and RESET_PC constants.
- One sub-module: if_id_reg, the IF/ID register with load, flush and valid/ready drain logic.
- The PC register and FSM stay in fetch_pc_ctrl.

Test Plan:
- Sequential fetch, id_ready=1, fetch model returns 32'h00550533 at PC 0: pc goes 0, 4, 8; if_pc=0 and if_instr=32'h00550533 on the cycle after reset deassert.
- Stall, id_ready=0 for 3 cycles with if_valid=1: pc, if_pc and if_instr hold; release -> next entry loads on the following edge.
- Redirect in the same cycle as a load, redirect_pc=64'h40: if_valid=0 next cycle, pc=64'h40, then entry if_pc=64'h40.
- Fault, redirect_pc=64'h2: fetch_inv_addr=1 -> fault=1, fault_pc=64'h2, pc frozen; redirect to 64'h10 -> fault=0, fetch resumes at 64'h10.
- Halt, fetch returns 32'h00000073 at PC 8: entry loaded with if_pc=8, halted=1, pc stays 8; redirect ignored; asserting reset restores pc=RESET_PC and halted=0.
- Wrap, redirect to 64'hFFFF_FFFF_FFFF_FFFC, valid fetch: next pc=0.
- With FETCH_PERF_CNT_EN defined, run the stall and wrap scenarios: fetch_count and stall_count match the expected increments for those scenarios.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC controller and its IF/ID register.
package fetch_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned ILEN    = 32;
  localparam int unsigned STATE_W = 2;

  localparam logic [XLEN-1:0] DEF_RESET_PC   = XLEN'(0);
  localparam logic [ILEN-1:0] DEF_HALT_INSTR = 32'h0000_0073;
  localparam int unsigned     DEF_PC_STEP    = 4;

  typedef enum logic [STATE_W-1:0] {
    S_RUN   = 2'd0,
    S_FAULT = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } if_entry_t;

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-memory, redirect and IF/ID signals between the PC controller and its neighbours.
interface fetch_pc_ctrl_if;
  import fetch_pkg::*;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_ready;
  logic [ILEN-1:0] fetch_instr;
  logic            fetch_inv_addr;
  logic [XLEN-1:0] pc;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [ILEN-1:0] if_instr;
  logic            fault;
  logic [XLEN-1:0] fault_pc;
  logic            halted;

  modport master (
    input  redirect_valid, redirect_pc, id_ready, fetch_instr, fetch_inv_addr,
    output pc, if_valid, if_pc, if_instr, fault, fault_pc, halted
  );

  modport slave (
    output redirect_valid, redirect_pc, id_ready, fetch_instr, fetch_inv_addr,
    input  pc, if_valid, if_pc, if_instr, fault, fault_pc, halted
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load from fetch, flush on redirect, drain on decode ready.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      load_i,
  input  logic      flush_i,
  input  logic      ready_i,
  input  if_entry_t entry_i,
  output logic      valid_o,
  output if_entry_t entry_o
);

  logic      valid_d, valid_q;
  if_entry_t entry_d, entry_q;

  // Flush beats a same-cycle load; otherwise a consumed entry simply drains.
  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      entry_d = entry_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign valid_o = valid_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Program counter, run/fault/halt control and IF/ID capture for instruction fetch.
// Optional FETCH_PERF_CNT_EN adds fetch_count/stall_count performance counters.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [ILEN-1:0] HALT_INSTR = DEF_HALT_INSTR,
  parameter int unsigned     PC_STEP    = DEF_PC_STEP
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]           fetch_count,
  output logic [31:0]           stall_count,
`endif
  fetch_pc_ctrl_if.master       bus
);

  fetch_state_e    state_d, state_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic [XLEN-1:0] fault_pc_d, fault_pc_q;
  logic            fault_q, halted_q;
  logic            load, flush, slot_free, entry_valid;
  if_entry_t       entry_in, entry_out;

  assign slot_free = !entry_valid || bus.id_ready;
  assign entry_in  = '{pc: pc_q, instr: bus.fetch_instr};

  // Redirect wins outside S_HALT; a bad address faults before any capture.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    load       = 1'b0;
    flush      = 1'b0;
    if (bus.redirect_valid && (state_q != S_HALT)) begin
      pc_d    = bus.redirect_pc;
      flush   = 1'b1;
      state_d = S_RUN;
    end else if (state_q == S_RUN) begin
      if (bus.fetch_inv_addr) begin
        state_d    = S_FAULT;
        fault_pc_d = pc_q;
      end else if (slot_free) begin
        load = 1'b1;
        if (bus.fetch_instr == HALT_INSTR) begin
          state_d = S_HALT;
        end else begin
          pc_d = pc_q + XLEN'(PC_STEP);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      fault_pc_q <= XLEN'(0);
      fault_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
      fault_q    <= (state_d == S_FAULT);
      halted_q   <= (state_d == S_HALT);
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .flush_i (flush),
    .ready_i (bus.id_ready),
    .entry_i (entry_in),
    .valid_o (entry_valid),
    .entry_o (entry_out)
  );

  assign bus.pc       = pc_q;
  assign bus.if_valid = entry_valid;
  assign bus.if_pc    = entry_out.pc;
  assign bus.if_instr = entry_out.instr;
  assign bus.fault    = fault_q;
  assign bus.fault_pc = fault_pc_q;
  assign bus.halted   = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  // Free-running wrap counters; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (load) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if ((state_q == S_RUN) && !slot_free) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed scenarios, a spec-level model checked every cycle.
module tb_fetch_pc_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic        halt_on = 1'b0;
  logic [63:0] halt_pc = 64'h0;

  int total = 0;
  int bad   = 0;

  fetch_pc_ctrl_if bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count;
`endif

  fetch_pc_ctrl dut (
    .clk         (clk),
    .reset       (reset),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count (fetch_count),
    .stall_count (stall_count),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Fetch memory: halt word at halt_pc when enabled, else an address-derived pattern.
  function automatic logic [31:0] mem_f(input logic [63:0] a);
    if (halt_on && (a == halt_pc)) return 32'h0000_0073;
    return a[31:0] ^ 32'h0055_0533;
  endfunction

  assign bus.fetch_instr    = (halt_on && (bus.pc == halt_pc)) ? 32'h0000_0073
                                                              : (bus.pc[31:0] ^ 32'h0055_0533);
  assign bus.fetch_inv_addr = (bus.pc[1:0] != 2'b00);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Spec-level model: mode 0=running, 1=faulted, 2=halted.
  int          m_mode;
  logic [63:0] m_pc, m_ifpc, m_fpc;
  logic [31:0] m_ifinstr, m_fcnt, m_scnt, m_word;
  logic        m_valid, m_slot;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_pc = 64'h0; m_valid = 1'b0; m_ifpc = 64'h0; m_ifinstr = 32'h0;
      m_fpc = 64'h0; m_fcnt = 32'h0; m_scnt = 32'h0;
    end else begin
      m_slot = !m_valid || bus.id_ready;
      m_word = mem_f(m_pc);
      if (m_mode == 0 && !m_slot) m_scnt = m_scnt + 32'd1;
      if (bus.redirect_valid && m_mode != 2) begin
        m_pc = bus.redirect_pc; m_valid = 1'b0; m_mode = 0;
      end else if (m_mode == 0 && m_pc[1:0] != 2'b00) begin
        m_mode = 1; m_fpc = m_pc;
        if (m_valid && bus.id_ready) m_valid = 1'b0;
      end else if (m_mode == 0 && m_slot) begin
        m_ifpc = m_pc; m_ifinstr = m_word; m_valid = 1'b1; m_fcnt = m_fcnt + 32'd1;
        if (m_word == 32'h0000_0073) m_mode = 2;
        else m_pc = m_pc + 64'd4;
      end else if (m_mode != 0) begin
        if (m_valid && bus.id_ready) m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("pc", bus.pc, m_pc);
    chk("if_valid", 64'(bus.if_valid), 64'(m_valid));
    chk("if_pc", bus.if_pc, m_ifpc);
    chk("if_instr", 64'(bus.if_instr), 64'(m_ifinstr));
    chk("fault", 64'(bus.fault), 64'(m_mode == 1));
    chk("fault_pc", bus.fault_pc, m_fpc);
    chk("halted", 64'(bus.halted), 64'(m_mode == 2));
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count", 64'(fetch_count), 64'(m_fcnt));
    chk("stall_count", 64'(stall_count), 64'(m_scnt));
`endif
  end

  task automatic redirect(input logic [63:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    bus.id_ready       = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pc", bus.pc, 64'h0);
    chk("rst_valid", 64'(bus.if_valid), 64'h0);
    chk("rst_fault", 64'(bus.fault), 64'h0);
    chk("rst_halted", 64'(bus.halted), 64'h0);
    reset = 1'b0;

    // Sequential fetch
    @(negedge clk);
    chk("seq_ifpc", bus.if_pc, 64'h0);
    chk("seq_instr", 64'(bus.if_instr), 64'h0055_0533);
    chk("seq_pc4", bus.pc, 64'h4);
    @(negedge clk);
    chk("seq_pc8", bus.pc, 64'h8);

    // Stall for three cycles
    bus.id_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("stall_pc", bus.pc, 64'h8);
    chk("stall_ifpc", bus.if_pc, 64'h4);
    chk("stall_instr", 64'(bus.if_instr), 64'h0055_0537);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall3", 64'(stall_count), 64'd3);
    chk("perf_fetch2", 64'(fetch_count), 64'd2);
`endif
    bus.id_ready = 1'b1;
    @(negedge clk);
    chk("release_ifpc", bus.if_pc, 64'h8);
    chk("release_pc", bus.pc, 64'hC);

    // Redirect colliding with a load
    redirect(64'h40);
    chk("redir_valid", 64'(bus.if_valid), 64'h0);
    chk("redir_pc", bus.pc, 64'h40);
    @(negedge clk);
    chk("redir_ifpc", bus.if_pc, 64'h40);
    chk("redir_pc44", bus.pc, 64'h44);

    // Misaligned target faults, redirect recovers
    redirect(64'h2);
    @(negedge clk);
    chk("fault_set", 64'(bus.fault), 64'h1);
    chk("fault_pc2", bus.fault_pc, 64'h2);
    @(negedge clk);
    chk("fault_pc_frozen", bus.pc, 64'h2);
    redirect(64'h10);
    chk("fault_clear", 64'(bus.fault), 64'h0);
    chk("fault_pc_kept", bus.fault_pc, 64'h2);
    chk("resume_pc", bus.pc, 64'h10);
    @(negedge clk);
    chk("resume_ifpc", bus.if_pc, 64'h10);

    // Halt word at PC 8
    halt_on = 1'b1;
    halt_pc = 64'h8;
    redirect(64'h0);
    repeat (3) @(negedge clk);
    chk("halt_ifpc", bus.if_pc, 64'h8);
    chk("halt_instr", 64'(bus.if_instr), 64'h73);
    chk("halt_flag", 64'(bus.halted), 64'h1);
    chk("halt_pc", bus.pc, 64'h8);
    redirect(64'h40);
    chk("halt_ignore_pc", bus.pc, 64'h8);
    chk("halt_ignore_flag", 64'(bus.halted), 64'h1);
    chk("halt_drained", 64'(bus.if_valid), 64'h0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_pc", bus.pc, 64'h0);
    chk("async_rst_halted", 64'(bus.halted), 64'h0);
    halt_on = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // PC wrap at 2^64
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_top", bus.pc, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    chk("wrap_pc0", bus.pc, 64'h0);
    chk("wrap_ifpc", bus.if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_instr", 64'(bus.if_instr), 64'hFFAA_FACF);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_wrap_fetch", 64'(fetch_count), 64'd1);
    chk("perf_wrap_stall", 64'(stall_count), 64'd0);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
